// File: rtl/multicycle_control.sv
// Multicycle MIPS-style main controller: a Moore FSM sequencing fetch, decode
// and the per-instruction execute/memory/writeback steps. All outputs are
// combinational decodes of the current state (funct in EXECUTE/ALUWB, zero in
// BRANCH).
module multicycle_control (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic [2:0] ALUcontrol,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSrc,
   output logic       IorD,
   output logic       IRWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       PCEn,
   output logic [3:0] state
);

   localparam logic [3:0] S_FETCH   = 4'd0;
   localparam logic [3:0] S_DECODE  = 4'd1;
   localparam logic [3:0] S_MEMADR  = 4'd2;
   localparam logic [3:0] S_MEMRD   = 4'd3;
   localparam logic [3:0] S_MEMWB   = 4'd4;
   localparam logic [3:0] S_MEMWR   = 4'd5;
   localparam logic [3:0] S_EXECUTE = 4'd6;
   localparam logic [3:0] S_ALUWB   = 4'd7;
   localparam logic [3:0] S_BRANCH  = 4'd8;
   localparam logic [3:0] S_ADDIEX  = 4'd9;
   localparam logic [3:0] S_ADDIWB  = 4'd10;
   localparam logic [3:0] S_JUMP    = 4'd11;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   logic [3:0] state_q, state_d;
   logic [2:0] funct_alu;
   logic       funct_legal;

   // Next-state selection; unused encodings 12-15 fall back to FETCH.
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:   state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            if (opcode == OP_LW)      state_d = S_MEMRD;
            else if (opcode == OP_SW) state_d = S_MEMWR;
            else                      state_d = S_FETCH;
         end
         S_MEMRD:   state_d = S_MEMWB;
         S_EXECUTE: state_d = S_ALUWB;
         S_ADDIEX:  state_d = S_ADDIWB;
         default:   state_d = S_FETCH;
      endcase
   end

   // State register; asynchronous reset returns to FETCH immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // R-type funct decode to ALU operation and legality flag.
   always_comb begin
      funct_alu   = ALU_ADD;
      funct_legal = 1'b1;
      case (funct)
         F_ADD:   funct_alu = ALU_ADD;
         F_SUB:   funct_alu = ALU_SUB;
         F_AND:   funct_alu = ALU_AND;
         F_OR:    funct_alu = ALU_OR;
         F_SLT:   funct_alu = ALU_SLT;
         default: funct_legal = 1'b0;
      endcase
   end

   // Moore output decode; reset masks every write enable and parks the ALU on ADD.
   always_comb begin
      ALUcontrol = '0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = '0;
      PCSrc      = '0;
      IorD       = 1'b0;
      IRWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      PCEn       = 1'b0;
      case (state_q)
         S_FETCH: begin
            IRWrite    = 1'b1;
            ALUSrcB    = 2'b01;
            ALUcontrol = ALU_ADD;
            PCEn       = 1'b1;
         end
         S_DECODE: begin
            ALUSrcB    = 2'b11;
            ALUcontrol = ALU_ADD;
         end
         S_MEMADR, S_ADDIEX: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            ALUcontrol = ALU_ADD;
         end
         S_MEMRD: IorD = 1'b1;
         S_MEMWB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
         end
         S_MEMWR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
         end
         S_EXECUTE: begin
            ALUSrcA    = 1'b1;
            ALUcontrol = funct_alu;
         end
         S_ALUWB: begin
            RegDst   = 1'b1;
            RegWrite = funct_legal;
         end
         S_BRANCH: begin
            ALUSrcA    = 1'b1;
            ALUcontrol = ALU_SUB;
            PCSrc      = 2'b01;
            PCEn       = zero;
         end
         S_ADDIWB: RegWrite = 1'b1;
         S_JUMP: begin
            PCSrc = 2'b10;
            PCEn  = 1'b1;
         end
         default: ;
      endcase
      if (!rst_n) begin
         PCEn       = 1'b0;
         IRWrite    = 1'b0;
         MemWrite   = 1'b0;
         RegWrite   = 1'b0;
         ALUcontrol = ALU_ADD;
      end
   end

   assign state = state_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters: none; the state encoding and opcode/funct values are fixed by this document.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 opcode  in  6  instruction bits [31:26], taken from the instruction register.
REQ-005 funct  in  6  instruction bits [5:0].
REQ-006 zero  in  1  ALU zero flag, valid in BRANCH.
REQ-007 ALUcontrol  out  3  ALU operation code: 000 AND, 001 OR, 010 ADD, 100 AND-NOT, 101 OR-NOT, 110 SUB, 111 SLT.
REQ-008 ALUSrcA  out  1  0 selects PC, 1 selects register A.
REQ-009 ALUSrcB  out  2  00 selects B, 01 selects constant 4, 10 selects SignImm, 11 selects SignImm<<2.
REQ-010 PCSrc  out  2  00 selects ALUresult, 01 selects ALUOut, 10 selects jump target.
REQ-011 IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg  out  1 each  standard multicycle datapath enables and selects.
REQ-012 PCEn  out  1  PC write enable.
REQ-013 state  out  4  current state, for debug.

Function
REQ-014 Moore FSM with 12 states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; the state register updates on posedge clk.
REQ-015 All outputs are combinational decodes of state (plus funct in EXECUTE/ALUWB, and zero for PCEn); outputs stay stable from posedge through the ALU's negedge sample.
REQ-016 Any output not listed for a state is 0.
REQ-017 FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUcontrol=010, PCSrc=00, PCEn=1; next state is DECODE.
REQ-018 DECODE: ALUSrcA=0, ALUSrcB=11, ALUcontrol=010 (branch target precompute); next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXECUTE
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - any other opcode -> FETCH, with no write enable asserted.
REQ-019 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUcontrol=010; next state is MEMRD for lw, MEMWR for sw.
REQ-020 MEMRD: IorD=1; next state is MEMWB.
REQ-021 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; next state is FETCH.
REQ-022 MEMWR: IorD=1, MemWrite=1; next state is FETCH.
REQ-023 EXECUTE: ALUSrcA=1, ALUSrcB=00; ALUcontrol by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, other -> 010; next state is ALUWB.
REQ-024 ALUWB: RegDst=1, MemtoReg=0; RegWrite=1 only for the five legal funct codes, otherwise 0; next state is FETCH.
REQ-025 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUcontrol=110, PCSrc=01, PCEn=zero; next state is FETCH.
REQ-026 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUcontrol=010; next state is ADDIWB.
REQ-027 ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1; next state is FETCH.
REQ-028 JUMP: PCSrc=10, PCEn=1; next state is FETCH.
REQ-029 Instruction latency in cycles, FETCH to return to FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2.
REQ-030 The encodings 12-15 are unreachable; if entered, the FSM goes to FETCH on the next edge with all enables 0.

Reset
REQ-031 When rst_n falls, state goes to FETCH immediately, regardless of clk.
REQ-032 While rst_n=0, PCEn, IRWrite, MemWrite and RegWrite are forced to 0; ALUcontrol=010.
REQ-033 Reset in mid-instruction abandons that instruction with no further writes.
REQ-034 The first rising edge after rst_n rises executes FETCH.

Verification
REQ-035 Reset, then opcode=100011 held -> state sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-036 opcode=000000, funct=101010 -> state sequence 0,1,6,7,0; ALUcontrol=111 in state 6; RegWrite=1 and RegDst=1 in state 7.
REQ-037 opcode=000100 with zero=1, then zero=0 -> PCEn=1 in state 8 for the first instruction, PCEn=0 for the second; PCSrc=01 both times.
REQ-038 opcode=111111 -> state sequence 0,1,0; no write enable asserted in state 1; funct=111111 in R-type -> RegWrite=0 in ALUWB.
REQ-039 rst_n pulsed low for 1 ns mid-MEMWR, away from any clk edge -> state=0 at once; MemWrite falls to 0 without waiting for an edge.
REQ-040 opcode=000010 -> state sequence 0,1,11,0; PCSrc=10 and PCEn=1 in state 11.
